onn_neuron_param: RTL and testbench

- Parametrised oscillatory neuron for the ONN array, successor to the fixed 4-bit neuron.
- Contains three parts: a phase-controlled oscillator (PCO), a phase-difference detector and a phase register.
- New over the fixed neuron: configurable phase resolution, an incremental phase-update mode and a settle detector.
- One instance per network node; `nin` is the coupled (weighted-sum) oscillation from the synapse layer, `nout` feeds the other neurons.

---
 rtl/onn_neuron_param.sv | 241 ++++++++++++++++++++++++
 tb/tb_onn_neuron_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/onn_neuron_param.sv
// -----------------------------------------------------------------------------
// onn_neuron_param
//   Parametrised oscillatory neuron for the ONN array. One instance per node.
//   Three parts:
//     * PCO            : free-running PB-bit counter offset by phi_out drives a
//                        50% duty square wave on nout (period 2^PB sclk cycles).
//     * phase detector : measures how many cycles nin's rising edge lags nout's
//                        rising edge and converts it to a target phase.
//     * phase register : phi_out, updated on drop either by a jump to the
//                        measured phase (STEP_MODE=0) or by one step toward it
//                        (STEP_MODE=1); a settle detector watches phi_out.
//
// Parameters
//   PB            phase resolution in bits (>= 2)
//   STEP_MODE     0 = jump to phase_meas on drop, 1 = step one LSB toward it
//   SETTLE_CHECKS consecutive unchanged state checks that assert settled
//
// Ports
//   sclk          system clock, all state on rising edge
//   re_n          asynchronous active-low reset
//   init          synchronous load of ini_phase, clears detector/settle logic
//   en            oscillator and detector enable
//   nin           coupled input oscillation (same clock domain)
//   drop          one-cycle strobe: apply the measured phase
//   state_check   one-cycle strobe: compare phi_out with the last snapshot
//   ini_phase     initial phase loaded by init
//   nout          registered output oscillation
//   phi_out       current neuron phase
//   phase_meas    last measured target phase
//   meas_valid    high while phase_meas has not been consumed by a drop
//   state_changed result of the last state_check
//   settled       phi_out unchanged for SETTLE_CHECKS consecutive checks
// -----------------------------------------------------------------------------
module onn_neuron_param #(
  parameter int PB            = 4,
  parameter int STEP_MODE     = 0,
  parameter int SETTLE_CHECKS = 3
) (
  input  logic          sclk,
  input  logic          re_n,
  input  logic          init,
  input  logic          en,
  input  logic          nin,
  input  logic          drop,
  input  logic          state_check,
  input  logic [PB-1:0] ini_phase,
  output logic          nout,
  output logic [PB-1:0] phi_out,
  output logic [PB-1:0] phase_meas,
  output logic          meas_valid,
  output logic          state_changed,
  output logic          settled
);

  typedef enum logic {ARMED = 1'b0, COUNT = 1'b1} det_state_t;

  localparam logic [PB-1:0] PB_ONE = {{(PB-1){1'b0}}, 1'b1};
  localparam logic [PB-1:0] D_MAX  = '1;
  // Half a period: a difference up to and including this is "ahead".
  localparam logic [PB-1:0] HALF   = {1'b1, {(PB-1){1'b0}}};
  localparam logic [7:0]    SC_MAX = 8'(SETTLE_CHECKS);

  logic [PB-1:0] cnt;
  logic [PB-1:0] local_phase;
  logic          nout_d;
  logic          nin_d;
  logic          nout_rise;
  logic          nin_rise;

  det_state_t    state_q;
  det_state_t    state_d;
  logic [PB-1:0] d_q;
  logic          meas_fire;
  logic [PB-1:0] meas_delay;
  logic          d_load;
  logic          d_inc;

  logic          drop_ok;
  logic [PB-1:0] diff;
  logic [PB-1:0] phi_step;
  logic [PB-1:0] drop_phi;

  logic [PB-1:0] snapshot;
  logic [7:0]    settle_cnt;
  logic [7:0]    settle_inc;
  logic          phase_changed;

  assign local_phase = cnt + phi_out;
  assign nout_rise   = nout & ~nout_d;
  assign nin_rise    = nin & ~nin_d;
  assign drop_ok     = drop & meas_valid;

  // ---------------------------------------------------------------------------
  // PCO and phase register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register (e.g. a state_check in
  // the same cycle as a drop sees the old phi_out).
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      cnt     <= '0;
      phi_out <= '0;
      nout    <= 1'b0;
      nout_d  <= 1'b0;
      nin_d   <= 1'b0;
    end else begin
      nout   <= ~local_phase[PB-1];
      nout_d <= nout;
      nin_d  <= nin;
      if (init) begin
        cnt     <= '0;
        phi_out <= ini_phase;
      end else begin
        if (en)      cnt     <= cnt + PB_ONE;
        if (drop_ok) phi_out <= drop_phi;
      end
    end
  end

  // Step toward phase_meas along the shorter way round the circle.
  assign diff = phase_meas - phi_out;

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    phi_step = phi_out;
    if (diff != '0) begin
      if (diff <= HALF) phi_step = phi_out + PB_ONE;
      else              phi_step = phi_out - PB_ONE;
    end
  end

  assign drop_phi = (STEP_MODE == 0) ? phase_meas : phi_step;

  // ---------------------------------------------------------------------------
  // Phase-difference detector FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) state_q <= ARMED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ARMED;
    end else if (en) begin
      unique case (state_q)
        ARMED: if (nout_rise && !nin_rise) state_d = COUNT;
        COUNT: begin
          if (nin_rise)            state_d = ARMED;
          else if (nout_rise)      state_d = COUNT;
          else if (d_q == D_MAX)   state_d = ARMED;  // timeout, nothing measured
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // d_q counts cycles since nout rose minus one, so the lag at the nin edge
  // is d_q + 1; coincident edges give a lag of zero.
  always_comb begin
    meas_fire  = 1'b0;
    meas_delay = '0;
    d_load     = 1'b0;
    d_inc      = 1'b0;
    if (!init && en) begin
      unique case (state_q)
        ARMED: begin
          if (nout_rise) begin
            if (nin_rise) meas_fire = 1'b1;
            else          d_load    = 1'b1;
          end
        end
        COUNT: begin
          if (nin_rise) begin
            meas_fire  = 1'b1;
            meas_delay = nout_rise ? '0 : d_q + PB_ONE;
          end else if (nout_rise) begin
            d_load = 1'b1;
          end else begin
            d_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      d_q        <= '0;
      phase_meas <= '0;
      meas_valid <= 1'b0;
    end else if (init) begin
      d_q        <= '0;
      meas_valid <= 1'b0;
    end else begin
      if (d_load)     d_q <= '0;
      else if (d_inc) d_q <= d_q + PB_ONE;
      // A measurement landing together with a drop wins and stays valid.
      if (meas_fire) begin
        phase_meas <= phi_out - meas_delay;
        meas_valid <= 1'b1;
      end else if (drop_ok) begin
        meas_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Settle detector
  // ---------------------------------------------------------------------------
  assign phase_changed = (phi_out != snapshot);
  assign settle_inc    = (settle_cnt == SC_MAX) ? settle_cnt : settle_cnt + 8'd1;

  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      snapshot      <= '0;
      settle_cnt    <= '0;
      state_changed <= 1'b0;
      settled       <= 1'b0;
    end else if (init) begin
      snapshot      <= ini_phase;
      settle_cnt    <= '0;
      state_changed <= 1'b0;
      settled       <= 1'b0;
    end else if (state_check) begin
      state_changed <= phase_changed;
      snapshot      <= phi_out;
      if (phase_changed) begin
        settle_cnt <= '0;
        settled    <= 1'b0;
      end else begin
        settle_cnt <= settle_inc;
        settled    <= (settle_inc == SC_MAX);
      end
    end
  end

endmodule

// File: tb/tb_onn_neuron_param.sv
// -----------------------------------------------------------------------------
// tb_onn_neuron_param
//   Two neurons (jump mode and step mode) share one stimulus. A table of
//   measurement scenarios gives hand-computed measured phases and the phi_out
//   each mode must reach after a drop; directed sequences cover reset, PCO
//   waveform/offset, settle logic, timeout and asynchronous reset mid-COUNT.
// -----------------------------------------------------------------------------
module tb_onn_neuron_param;

  logic       sclk = 1'b0;
  logic       re_n = 1'b0;
  logic       init = 1'b0;
  logic       en = 1'b0;
  logic       nin = 1'b0;
  logic       drop = 1'b0;
  logic       state_check = 1'b0;
  logic [3:0] ini_phase = 4'd0;

  logic       nout0, nout1;
  logic [3:0] phi0, phi1, pm0, pm1;
  logic       mv0, mv1, sc0, sc1, st0, st1;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  onn_neuron_param #(.PB(4), .STEP_MODE(0), .SETTLE_CHECKS(3)) dut0 (
    .sclk(sclk), .re_n(re_n), .init(init), .en(en), .nin(nin), .drop(drop),
    .state_check(state_check), .ini_phase(ini_phase), .nout(nout0),
    .phi_out(phi0), .phase_meas(pm0), .meas_valid(mv0),
    .state_changed(sc0), .settled(st0)
  );

  onn_neuron_param #(.PB(4), .STEP_MODE(1), .SETTLE_CHECKS(3)) dut1 (
    .sclk(sclk), .re_n(re_n), .init(init), .en(en), .nin(nin), .drop(drop),
    .state_check(state_check), .ini_phase(ini_phase), .nout(nout1),
    .phi_out(phi1), .phase_meas(pm1), .meas_valid(mv1),
    .state_changed(sc1), .settled(st1)
  );

  typedef struct {
    int ini;       // ini_phase loaded by init
    int delay;     // cycles nin's rising edge lags nout's
    int exp_meas;  // (ini - delay) mod 16
    int exp_jump;  // phi_out after drop, jump mode
    int exp_step;  // phi_out after drop, step mode
  } meas_vec_t;

  meas_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // nout level observed after the k-th rising edge following the init edge.
  function automatic logic nout_model(input int k, input int p);
    int m;
    m = (((k - 1 + p) % 16) + 16) % 16;
    return (m < 8);
  endfunction

  task automatic do_init(input int p);
    @(negedge sclk);
    init      = 1'b1;
    ini_phase = 4'(p);
    en        = 1'b1;
    nin       = 1'b0;
    @(negedge sclk);
    init      = 1'b0;
  endtask

  // Runs n cycles after init; nin is nout's model delayed by 'delay' cycles
  // (delay < 0 holds nin low). Optionally checks nout of both neurons.
  task automatic run(input int p, input int delay, input int n, input bit chk_nout);
    nin = (delay < 0) ? 1'b0 : nout_model(-delay, p);
    for (int k = 1; k <= n; k++) begin
      @(negedge sclk);
      if (chk_nout) begin
        check($sformatf("nout0 p=%0d k=%0d", p, k), 32'(nout0), 32'(nout_model(k, p)));
        check($sformatf("nout1 p=%0d k=%0d", p, k), 32'(nout1), 32'(nout_model(k, p)));
      end
      nin = (delay < 0) ? 1'b0 : nout_model(k - delay, p);
    end
  endtask

  task automatic pulse(input logic d, input logic s);
    @(negedge sclk);
    drop        = d;
    state_check = s;
    @(negedge sclk);
    drop        = 1'b0;
    state_check = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " nout0"}, 32'(nout0), 32'd0);
    check({tag, " phi0"},  32'(phi0),  32'd0);
    check({tag, " pm0"},   32'(pm0),   32'd0);
    check({tag, " mv0"},   32'(mv0),   32'd0);
    check({tag, " sc0"},   32'(sc0),   32'd0);
    check({tag, " st0"},   32'(st0),   32'd0);
    check({tag, " phi1"},  32'(phi1),  32'd0);
    check({tag, " pm1"},   32'(pm1),   32'd0);
    check({tag, " mv1"},   32'(mv1),   32'd0);
  endtask

  initial begin
    vecs[0] = '{ini: 0,  delay: 3,  exp_meas: 13, exp_jump: 13, exp_step: 15};
    vecs[1] = '{ini: 2,  delay: 4,  exp_meas: 14, exp_jump: 14, exp_step: 1};
    vecs[2] = '{ini: 2,  delay: 8,  exp_meas: 10, exp_jump: 10, exp_step: 3};
    vecs[3] = '{ini: 5,  delay: 0,  exp_meas: 5,  exp_jump: 5,  exp_step: 5};
    vecs[4] = '{ini: 7,  delay: 15, exp_meas: 8,  exp_jump: 8,  exp_step: 8};
    vecs[5] = '{ini: 12, delay: 1,  exp_meas: 11, exp_jump: 11, exp_step: 11};

    // Reset held with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge sclk);
      init        = 1'($urandom_range(0, 1));
      en          = 1'($urandom_range(0, 1));
      nin         = 1'($urandom_range(0, 1));
      drop        = 1'($urandom_range(0, 1));
      state_check = 1'($urandom_range(0, 1));
      ini_phase   = 4'($urandom_range(0, 15));
    end
    @(negedge sclk);
    check_all_zero("reset");
    init = 0; en = 0; nin = 0; drop = 0; state_check = 0; ini_phase = 0;
    re_n = 1'b1;

    // PCO waveform and phase offset.
    do_init(0);
    run(0, -1, 32, 1'b1);
    do_init(4);
    run(4, -1, 32, 1'b1);

    // Measurement, jump and step scenarios.
    for (int i = 0; i < 6; i++) begin
      do_init(vecs[i].ini);
      run(vecs[i].ini, vecs[i].delay, 48, 1'b0);
      nin = 1'b0;
      @(negedge sclk);
      check($sformatf("v%0d meas0", i),  32'(pm0), 32'(vecs[i].exp_meas));
      check($sformatf("v%0d meas1", i),  32'(pm1), 32'(vecs[i].exp_meas));
      check($sformatf("v%0d valid0", i), 32'(mv0), 32'd1);
      check($sformatf("v%0d valid1", i), 32'(mv1), 32'd1);
      pulse(1'b1, 1'b0);
      check($sformatf("v%0d jump", i),   32'(phi0), 32'(vecs[i].exp_jump));
      check($sformatf("v%0d step", i),   32'(phi1), 32'(vecs[i].exp_step));
      check($sformatf("v%0d consumed0", i), 32'(mv0), 32'd0);
      check($sformatf("v%0d consumed1", i), 32'(mv1), 32'd0);
      pulse(1'b1, 1'b0);
      check($sformatf("v%0d ignored0", i), 32'(phi0), 32'(vecs[i].exp_jump));
      check($sformatf("v%0d ignored1", i), 32'(phi1), 32'(vecs[i].exp_step));
    end

    // Timeout: nin held low, nothing measured, old phase_meas kept.
    do_init(3);
    run(3, -1, 48, 1'b0);
    check("timeout valid0", 32'(mv0), 32'd0);
    check("timeout valid1", 32'(mv1), 32'd0);
    check("timeout meas0",  32'(pm0), 32'd11);
    check("timeout meas1",  32'(pm1), 32'd11);

    // Settle detector with a simultaneous drop and state_check.
    do_init(6);
    run(6, 3, 48, 1'b0);
    nin = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pulse(1'b0, 1'b1);
      check($sformatf("settle chg0 #%0d", i), 32'(sc0), 32'd0);
      check($sformatf("settle chg1 #%0d", i), 32'(sc1), 32'd0);
      check($sformatf("settled0 #%0d", i), 32'(st0), 32'(i >= 3));
      check($sformatf("settled1 #%0d", i), 32'(st1), 32'(i >= 3));
    end
    pulse(1'b1, 1'b1);
    check("simul chg0",   32'(sc0),  32'd0);
    check("simul st0",    32'(st0),  32'd1);
    check("simul phi0",   32'(phi0), 32'd3);
    check("simul phi1",   32'(phi1), 32'd5);
    pulse(1'b0, 1'b1);
    check("post chg0",    32'(sc0),  32'd1);
    check("post chg1",    32'(sc1),  32'd1);
    check("post st0",     32'(st0),  32'd0);
    check("post st1",     32'(st1),  32'd0);
    pulse(1'b0, 1'b1);
    check("again chg0",   32'(sc0),  32'd0);
    check("again st0",    32'(st0),  32'd0);

    // Asynchronous reset while the detector is in COUNT.
    do_init(9);
    run(9, 3, 58, 1'b0);
    check("pre-reset meas0",  32'(pm0), 32'd6);
    check("pre-reset valid0", 32'(mv0), 32'd1);
    check("pre-reset phi0",   32'(phi0), 32'd9);
    #2 re_n = 1'b0;
    #1 check_all_zero("async");
    @(negedge sclk);
    nin = 1'b0;
    @(negedge sclk);
    re_n = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge sclk);
    check("post-reset meas0",  32'(pm0), 32'd0);
    check("post-reset valid0", 32'(mv0), 32'd0);
    check("post-reset valid1", 32'(mv1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
